// File: rtl/data_mem_pkg.sv
// Shared definitions for the wait-state data memory.
// Holds the FSM state encoding and the default parameter values used by
// data_mem_ws and data_mem_array.
package data_mem_pkg;

    localparam int unsigned DefDataW        = 32;
    localparam int unsigned DefAddrW        = 18;
    localparam int unsigned DefDepth        = 16384;
    localparam int unsigned DefBaseAddr     = 1024;
    localparam int unsigned DefWaitCycles   = 2;
    localparam int unsigned DefClearOnReset = 1;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/data_mem_array.sv
// Word storage for data_mem_ws.
// One synchronous write port with per-byte-lane enables, one asynchronous
// read port. Contents are not reset, so they survive a reset unless the
// owner sweeps them.
// Ports:
//   clk    clock, rising edge
//   we     write strobe
//   waddr  write word index
//   wdata  write data
//   wbe    byte-lane enables for the write
//   raddr  read word index
//   rdata  read data (combinational from raddr)
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DATA_W / 8); i++) begin
            if (we && wbe[i]) begin
                mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_ws.sv
// Single-port data memory with a fixed number of wait states.
// A request is accepted in IDLE, held for WAIT_CYCLES cycles, then answered
// with a one-cycle response strobe. Writes commit on the edge that ends the
// response cycle. After reset the memory is optionally swept to zero, one
// word per cycle, before requests are accepted.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   req_valid  request present
//   req_ready  request can be accepted this cycle
//   req_we     1 = write, 0 = read
//   req_addr   byte address
//   req_wdata  write data
//   req_be     byte enables, bit i covers byte lane i
//   rsp_valid  one-cycle response strobe
//   rsp_rdata  read data, zero unless a good read is being answered
//   rsp_err    address error, valid with rsp_valid
module data_mem_ws
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W         = DefDataW,
    parameter int unsigned ADDR_W         = DefAddrW,
    parameter int unsigned DEPTH          = DefDepth,
    parameter int unsigned BASE_ADDR      = DefBaseAddr,
    parameter int unsigned WAIT_CYCLES    = DefWaitCycles,
    parameter int unsigned CLEAR_ON_RESET = DefClearOnReset
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int unsigned BeW  = DATA_W / 8;
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Address decode, one bit wider than the address so the subtraction
    // below BASE_ADDR cannot alias into range.
    logic [ADDR_W:0]   byte_off;
    logic [ADDR_W:0]   word_off;
    logic              addr_err;
    logic [IdxW-1:0]   req_idx;
    logic              unused_word_off;

    assign byte_off = {1'b0, req_addr} - (ADDR_W + 1)'(BASE_ADDR);
    assign word_off = byte_off >> 2;
    assign addr_err = (req_addr < ADDR_W'(BASE_ADDR)) ||
                      (word_off >= (ADDR_W + 1)'(DEPTH)) ||
                      (req_addr[1:0] != 2'b00);
    assign req_idx  = word_off[IdxW-1:0];
    assign unused_word_off = ^word_off[ADDR_W:IdxW];

    // State and latched request.
    state_e             state_q, state_d;
    logic [3:0]         wait_q, wait_d;
    logic [IdxW-1:0]    clr_q, clr_d;
    logic               accept;
    logic               we_q;
    logic               err_q;
    logic [IdxW-1:0]    idx_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [BeW-1:0]     be_q;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        clr_d     = clr_q;
        accept    = 1'b0;
        req_ready = 1'b0;
        unique case (state_q)
            StInit: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == IdxW'(DEPTH - 1)) begin
                    clr_d   = '0;
                    state_d = StIdle;
                end
            end
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                    end else begin
                        wait_d  = 4'(WAIT_CYCLES);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                wait_d = wait_q - 1'b1;
                // The cycle holding a count of 1 is the last wait state.
                if (wait_q <= 4'd1) begin
                    wait_d  = '0;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? StInit : StIdle;
            wait_q  <= '0;
            clr_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            clr_q   <= clr_d;
            if (accept) begin
                we_q    <= req_we;
                err_q   <= addr_err;
                idx_q   <= req_idx;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    // Storage port muxing: the init sweep owns the write port in StInit,
    // otherwise a good write commits on the edge leaving StResp.
    logic               mem_we;
    logic [IdxW-1:0]    mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [BeW-1:0]     mem_be;
    logic [DATA_W-1:0]  mem_rdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx_q;
        mem_wdata = wdata_q;
        mem_be    = be_q;
        if (state_q == StInit) begin
            mem_we    = 1'b1;
            mem_waddr = clr_q;
            mem_wdata = '0;
            mem_be    = '1;
        end else if (state_q == StResp) begin
            mem_we = we_q && !err_q;
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IdxW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .wbe   (mem_be),
        .raddr (idx_q),
        .rdata (mem_rdata)
    );

    // Response outputs derive only from registered state, so they are zero
    // in reset and outside StResp.
    assign rsp_valid = (state_q == StResp);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_ws.sv
// Scoreboard bench for data_mem_ws (DEPTH=16, WAIT_CYCLES=2, BASE_ADDR=1024,
// CLEAR_ON_RESET=1). The driver pushes expected responses at acceptance; a
// monitor on the falling edge pops and compares whenever rsp_valid is high.
module tb_data_mem_ws;

    localparam int Lat = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [17:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    data_mem_ws #(
        .DATA_W         (32),
        .ADDR_W         (18),
        .DEPTH          (16),
        .BASE_ADDR      (1024),
        .WAIT_CYCLES    (2),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        int          tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: compare each response against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("rsp%0d_rdata", e.tag), rsp_rdata, e.rdata);
                    check($sformatf("rsp%0d_err", e.tag), {31'b0, rsp_err}, {31'b0, e.err});
                    check($sformatf("rsp%0d_latency_cycle", e.tag), cyc + 1, e.due);
                end
            end else begin
                check("idle_rdata_zero", rsp_rdata, 32'h0);
                check("idle_err_zero", {31'b0, rsp_err}, 32'h0);
            end
        end
    end

    // Present a request from a falling edge and hold it until accepted.
    // acc is the index of the accepting rising edge (value cyc takes there).
    task automatic issue(input logic we, input logic [17:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rdata,
                         input logic exp_err, input bit push, input int tag,
                         output int acc);
        int n;
        @(negedge clk);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout tag %0d: req_ready=0 after %0d cycles, required 1", tag, n);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (push) sb.push_back('{exp_rdata, exp_err, acc + Lat, tag});
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(name, n, 16);
    endtask

    initial begin
        int acc;
        int prev;
        int n;
        logic [31:0] exp;

        repeat (3) @(negedge clk);
        check("reset_req_ready", {31'b0, req_ready}, 32'h0);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", {31'b0, rsp_err}, 32'h0);

        rst = 1'b1;
        wait_init("init_ready_low_cycles");

        issue(1'b0, 18'd1024, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1, acc); idle();
        issue(1'b1, 18'd1028, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b1, 2, acc); idle();
        issue(1'b0, 18'd1028, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1, 3, acc); idle();
        issue(1'b1, 18'd1028, 32'h11223344, 4'b0101, 32'h0, 1'b0, 1'b1, 4, acc); idle();
        issue(1'b0, 18'd1028, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 1'b1, 5, acc); idle();

        // Address errors: below base, past the end, misaligned.
        issue(1'b0, 18'd1020, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 6, acc); idle();
        issue(1'b0, 18'd1088, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 7, acc); idle();
        issue(1'b0, 18'd1026, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 8, acc); idle();
        issue(1'b1, 18'd1088, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1'b1, 9, acc); idle();
        for (int i = 0; i < 16; i++) begin
            exp = (i == 1) ? 32'hDE22BE44 : 32'h0;
            issue(1'b0, 18'(1024 + 4 * i), 32'h0, 4'h0, exp, 1'b0, 1'b1, 100 + i, acc);
            idle();
        end

        // Write with no lanes enabled completes cleanly and changes nothing.
        issue(1'b1, 18'd1028, 32'h55555555, 4'h0, 32'h0, 1'b0, 1'b1, 10, acc); idle();
        issue(1'b0, 18'd1028, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 1'b1, 11, acc); idle();

        // Reset during the wait states of a write aborts it.
        issue(1'b1, 18'd1032, 32'hAAAA5555, 4'hF, 32'h0, 1'b0, 1'b0, 12, acc);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midwait_reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("midwait_reset_req_ready", {31'b0, req_ready}, 32'h0);
        rst = 1'b1;
        wait_init("reinit_ready_low_cycles");
        issue(1'b0, 18'd1032, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 13, acc); idle();
        issue(1'b0, 18'd1028, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 14, acc); idle();

        // req_valid held high: writes then reads with incrementing addresses.
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 18'(1024 + 4 * i), 32'hA0000000 + 32'(i), 4'hF, 32'h0, 1'b0, 1'b1,
                  200 + i, acc);
            if (prev >= 0) check($sformatf("b2b_spacing_w%0d", i), acc - prev, 4);
            prev = acc;
        end
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 18'(1024 + 4 * i), 32'h0, 4'h0, 32'hA0000000 + 32'(i), 1'b0, 1'b1,
                  300 + i, acc);
            check($sformatf("b2b_spacing_r%0d", i), acc - prev, 4);
            prev = acc;
        end
        idle();

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 32'h0);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
